fwd_scoreboard: RTL and testbench
=================================

# fwd_scoreboard

Parametrised successor to the fixed two-stage forwarding unit used in the 5-stage CPU. It keeps its own shift-register history of the last DEPTH retiring results (destination, data, load-pending flag) and drives EX operands directly. It generates the ID-stage load-use stall and counts stall cycles. It sits between the ID/EX register outputs and the ALU input muxes, replacing the external forward muxes and the load-use part of the hazard unit.

## Interface
- DATA_W, 32, operand/result width
- REG_W, 5, register-address width
- DEPTH, 3, tracked in-flight results (entry 0 = EX/MEM, 1 = MEM/WB, 2 = one cycle after writeback); legal range 2..8
- ZERO_REG, 1, when 1 register 0 is never forwarded nor stalled on
- SEL_W, 4, width of selector outputs; must satisfy 2^SEL_W > DEPTH
- clk  input  1  clock, all state updates on rising edge
- Reset  input  1  asynchronous active-low reset
- id_rs, id_rt  input  REG_W  source registers of the instruction in ID
- id_use_rs, id_use_rt  input  1  ID instruction actually reads rs / rt
- ex_rs, ex_rt  input  REG_W  source registers of the instruction in EX
- ex_rf_a, ex_rf_b  input  DATA_W  register-file values latched in ID/EX
- ex_valid  input  1  EX holds a real instruction (0 = bubble)
- ex_wr  input  1  EX instruction writes a register
- ex_load  input  1  EX instruction is a load
- ex_dst  input  REG_W  EX destination (after RegDst mux)
- ex_result  input  DATA_W  EX result (after ALU result mux)
- mem_ld_data  input  DATA_W  data-memory output for the instruction in MEM
- op_a, op_b  output  DATA_W  forwarded EX operands
- sel_a, sel_b  output  SEL_W  0 = register file, k+1 = entry k
- stall  output  1  hold PC and IF/ID; insert bubble into ID/EX
- hazard_err  output  1  EX operand matched a load whose data is not yet present
- stall_cnt  output  16  saturating count of stall cycles

## Operation
- Entry fields: v, dst, data, pend. Writeable means v=1 and (ZERO_REG=0 or dst≠0).
- Entry 0 ← {ex_valid&ex_wr, ex_dst, ex_result, ex_load} every cycle. No enable; bubbles arrive as ex_valid=0.
- Entry 1 ← entry 0, except data ← mem_ld_data and pend ← 0 when entry 0 pend=1.
- Entry k+1 ← entry k for k≥1. The oldest entry is discarded.
- Forward A: scan entries 0..DEPTH-1 youngest first. The first writeable entry with dst==ex_rs wins. op_a = its data, sel_a = k+1. With no hit, op_a = ex_rf_a, sel_a = 0. B is identical using ex_rt/ex_rf_b.
- If the winning entry has pend=1, assert hazard_err and still output its (stale) data. This cannot occur when stall is honoured.
- stall = ex_valid & ex_wr & ex_load & writeable(ex_dst) & ((id_use_rs & ex_dst==id_rs) | (id_use_rt & ex_dst==id_rt)).
- stall_cnt increments on each cycle with stall=1 and saturates at 0xFFFF.

## Timing
- op_*, sel_*, stall and hazard_err are combinational from inputs and entry registers. There is no added latency.
- A result is forwardable the cycle after it is in EX, via entry 0. ALU results are forwardable from entry 0. Load results are forwardable from entry 1 onward.
- Load-use costs exactly one stall cycle. The dependent instruction then reads entry 1 (load data).
- DEPTH=3 covers a register file without write-through: entry 2 supplies the value being written that cycle.
- Reset asserted (at any time, including mid-stall) clears all v, pend, data and stall_cnt to 0 immediately. In reset, sel_a=sel_b=0 and op_a/op_b pass ex_rf_a/ex_rf_b. stall follows inputs only.
- Identical dst in several entries: the youngest wins.

## Test plan
- Back-to-back ALU: add r3 (result 0x11) in EX, next cycle ex_rs=3 -> op_a=0x11, sel_a=1, stall=0.
- Two-apart: r4=0x22 written, then bubble, then ex_rt=4 -> op_b=0x22, sel_b=2. With ex_rf_b=0x99 and no hit -> op_b=0x99, sel_b=0.
- Load-use: ex_load, ex_dst=5, id_rs=5, id_use_rs=1 -> stall=1 for one cycle, stall_cnt=1. Next cycle, with mem_ld_data=0xABCD and ex_rs=5 -> op_a=0xABCD, sel_a=2, hazard_err=0.
- Priority/zero: r6=1 then r6=2 in successive cycles, ex_rs=6 -> op_a=2, sel_a=1. With dst=0 and ZERO_REG=1 -> no forward, no stall.
- Protocol violation: load r7 in EX, ignore stall, next cycle ex_rs=7 -> hazard_err=1.
- Reset mid-stream: assert Reset with all entries full -> sel_a=sel_b=0 and stall_cnt=0 immediately; after release, the first forward comes only from post-reset results.

Source files
------------

// File: rtl/fwd_scoreboard_if.sv
// Operand-forwarding scoreboard bus: ID/EX pipeline inputs in, forwarded operands,
// selectors, load-use stall and diagnostics out.
interface fwd_scoreboard_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned SEL_W  = 4
);
   // ID-stage source operands
   logic [REG_W-1:0]  id_rs_i;
   logic [REG_W-1:0]  id_rt_i;
   logic              id_use_rs_i;
   logic              id_use_rt_i;

   // EX-stage sources and register-file values
   logic [REG_W-1:0]  ex_rs_i;
   logic [REG_W-1:0]  ex_rt_i;
   logic [DATA_W-1:0] ex_rf_a_i;
   logic [DATA_W-1:0] ex_rf_b_i;

   // EX-stage producer
   logic              ex_valid_i;
   logic              ex_wr_i;
   logic              ex_load_i;
   logic [REG_W-1:0]  ex_dst_i;
   logic [DATA_W-1:0] ex_result_i;

   // Data-memory read data for the instruction in MEM
   logic [DATA_W-1:0] mem_ld_data_i;

   // Results
   logic [DATA_W-1:0] op_a_o;
   logic [DATA_W-1:0] op_b_o;
   logic [SEL_W-1:0]  sel_a_o;
   logic [SEL_W-1:0]  sel_b_o;
   logic              stall_o;
   logic              hazard_err_o;
   logic [15:0]       stall_cnt_o;

   modport slave (
      input  id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
      input  ex_rs_i, ex_rt_i, ex_rf_a_i, ex_rf_b_i,
      input  ex_valid_i, ex_wr_i, ex_load_i, ex_dst_i, ex_result_i,
      input  mem_ld_data_i,
      output op_a_o, op_b_o, sel_a_o, sel_b_o, stall_o, hazard_err_o, stall_cnt_o
   );

   modport master (
      output id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
      output ex_rs_i, ex_rt_i, ex_rf_a_i, ex_rf_b_i,
      output ex_valid_i, ex_wr_i, ex_load_i, ex_dst_i, ex_result_i,
      output mem_ld_data_i,
      input  op_a_o, op_b_o, sel_a_o, sel_b_o, stall_o, hazard_err_o, stall_cnt_o
   );
endinterface

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: shift-register history of the last DEPTH retiring results,
// youngest-first operand forwarding into EX, ID load-use stall and stall counter.
module fwd_scoreboard #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned REG_W    = 5,
   parameter int unsigned DEPTH    = 3,
   parameter bit          ZERO_REG = 1'b1,
   parameter int unsigned SEL_W    = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   fwd_scoreboard_if.slave bus
);

   // History entries; index 0 is the youngest (EX/MEM)
   logic [DEPTH-1:0]  v_q, v_d;
   logic [DEPTH-1:0]  pend_q, pend_d;
   logic [REG_W-1:0]  dst_q  [DEPTH];
   logic [REG_W-1:0]  dst_d  [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];

   logic [15:0]       cnt_q, cnt_d;

   logic [DEPTH-1:0]  wr_ok;
   logic              ex_dst_ok;
   logic              stall;

   logic [DATA_W-1:0] op_a, op_b;
   logic [SEL_W-1:0]  sel_a, sel_b;
   logic              haz_a, haz_b;
   logic              hit_a, hit_b;

   // An entry can supply a value only if it writes a real (non-hardwired) register
   always_comb begin
      wr_ok = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         wr_ok[k] = v_q[k] & (!ZERO_REG | (dst_q[k] != '0));
      end
   end

   // Next history: capture EX into entry 0, shift older entries down
   always_comb begin
      v_d    = '0;
      pend_d = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         dst_d[k]  = '0;
         data_d[k] = '0;
      end

      v_d[0]    = bus.ex_valid_i & bus.ex_wr_i;
      dst_d[0]  = bus.ex_dst_i;
      data_d[0] = bus.ex_result_i;
      pend_d[0] = bus.ex_load_i;

      // A pending load picks up its memory data on the way from entry 0 to entry 1,
      // so nothing at entry 1 or older is ever pending.
      v_d[1]    = v_q[0];
      dst_d[1]  = dst_q[0];
      data_d[1] = pend_q[0] ? bus.mem_ld_data_i : data_q[0];
      pend_d[1] = 1'b0;

      for (int unsigned k = 2; k < DEPTH; k++) begin
         v_d[k]    = v_q[k-1];
         dst_d[k]  = dst_q[k-1];
         data_d[k] = data_q[k-1];
         pend_d[k] = pend_q[k-1];
      end
   end

   // History register; reset wipes every entry immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q    <= '0;
         pend_q <= '0;
         for (int unsigned k = 0; k < DEPTH; k++) begin
            dst_q[k]  <= '0;
            data_q[k] <= '0;
         end
      end else begin
         v_q    <= v_d;
         pend_q <= pend_d;
         for (int unsigned k = 0; k < DEPTH; k++) begin
            dst_q[k]  <= dst_d[k];
            data_q[k] <= data_d[k];
         end
      end
   end

   // Operand A: youngest matching writeable entry wins, else register file
   always_comb begin
      op_a  = bus.ex_rf_a_i;
      sel_a = '0;
      haz_a = 1'b0;
      hit_a = 1'b0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (!hit_a && wr_ok[k] && (dst_q[k] == bus.ex_rs_i)) begin
            hit_a = 1'b1;
            op_a  = data_q[k];
            sel_a = SEL_W'(k + 1);
            haz_a = pend_q[k];
         end
      end
   end

   // Operand B: same rule as A using rt
   always_comb begin
      op_b  = bus.ex_rf_b_i;
      sel_b = '0;
      haz_b = 1'b0;
      hit_b = 1'b0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (!hit_b && wr_ok[k] && (dst_q[k] == bus.ex_rt_i)) begin
            hit_b = 1'b1;
            op_b  = data_q[k];
            sel_b = SEL_W'(k + 1);
            haz_b = pend_q[k];
         end
      end
   end

   // Load-use stall: a load in EX feeds a register the ID instruction reads
   always_comb begin
      ex_dst_ok = !ZERO_REG | (bus.ex_dst_i != '0);
      stall     = bus.ex_valid_i & bus.ex_wr_i & bus.ex_load_i & ex_dst_ok &
                  ((bus.id_use_rs_i & (bus.ex_dst_i == bus.id_rs_i)) |
                   (bus.id_use_rt_i & (bus.ex_dst_i == bus.id_rt_i)));
   end

   // Saturating stall-cycle counter next state
   always_comb begin
      cnt_d = cnt_q;
      if (stall && (cnt_q != '1)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // Stall-cycle counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Drive the bus outputs
   always_comb begin
      bus.op_a_o       = op_a;
      bus.op_b_o       = op_b;
      bus.sel_a_o      = sel_a;
      bus.sel_b_o      = sel_b;
      bus.stall_o      = stall;
      bus.hazard_err_o = haz_a | haz_b;
      bus.stall_cnt_o  = cnt_q;
   end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios plus randomized traffic
// compared against a queue-based model of in-flight results.
module tb_fwd_scoreboard;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned DEPTH  = 3;
   localparam int unsigned SEL_W  = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   passed = 0;

   fwd_scoreboard_if #(.DATA_W(DATA_W), .REG_W(REG_W), .SEL_W(SEL_W)) bus ();

   fwd_scoreboard #(
      .DATA_W  (DATA_W),
      .REG_W   (REG_W),
      .DEPTH   (DEPTH),
      .ZERO_REG(1'b1),
      .SEL_W   (SEL_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Reference model: list of recently retired instructions, youngest first
   typedef struct {
      bit                v;
      logic [REG_W-1:0]  dst;
      logic [DATA_W-1:0] data;
      bit                pend;
   } rec_t;

   rec_t        hist[$];
   int unsigned exp_cnt;

   function automatic void model_clear();
      rec_t e;
      e.v = 0; e.dst = '0; e.data = '0; e.pend = 0;
      hist.delete();
      for (int i = 0; i < DEPTH; i++) hist.push_back(e);
      exp_cnt = 0;
   endfunction

   function automatic bit model_stall();
      return bus.ex_valid_i && bus.ex_wr_i && bus.ex_load_i && (bus.ex_dst_i != 0) &&
             ((bus.id_use_rs_i && bus.ex_dst_i == bus.id_rs_i) ||
              (bus.id_use_rt_i && bus.ex_dst_i == bus.id_rt_i));
   endfunction

   function automatic void model_fwd(input logic [REG_W-1:0] r, input logic [DATA_W-1:0] rf,
                                     output logic [DATA_W-1:0] op, output logic [SEL_W-1:0] sel,
                                     output logic haz);
      op = rf; sel = '0; haz = 1'b0;
      for (int i = 0; i < hist.size(); i++) begin
         if (hist[i].v && hist[i].dst != 0 && hist[i].dst == r) begin
            op  = hist[i].data;
            sel = SEL_W'(i + 1);
            haz = hist[i].pend;
            return;
         end
      end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      rec_t y;
      rec_t n;
      if (!rst_n) begin
         model_clear();
      end else begin
         if (model_stall() && exp_cnt < 65535) exp_cnt++;
         y = hist[0];
         if (y.pend) begin
            y.data = bus.mem_ld_data_i;
            y.pend = 0;
            hist[0] = y;
         end
         n.v    = bus.ex_valid_i && bus.ex_wr_i;
         n.dst  = bus.ex_dst_i;
         n.data = bus.ex_result_i;
         n.pend = bus.ex_load_i;
         hist.push_front(n);
         void'(hist.pop_back());
      end
   end

   logic [DATA_W-1:0] ea, eb;
   logic [SEL_W-1:0]  esa, esb;
   logic              eha, ehb;

   task automatic drive_idle();
      bus.id_rs_i = '0; bus.id_rt_i = '0; bus.id_use_rs_i = 0; bus.id_use_rt_i = 0;
      bus.ex_rs_i = '0; bus.ex_rt_i = '0; bus.ex_rf_a_i = '0; bus.ex_rf_b_i = '0;
      bus.ex_valid_i = 0; bus.ex_wr_i = 0; bus.ex_load_i = 0;
      bus.ex_dst_i = '0; bus.ex_result_i = '0; bus.mem_ld_data_i = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic v, input logic wr, input logic ld,
                         input logic [REG_W-1:0] dst, input logic [DATA_W-1:0] res);
      bus.ex_valid_i = v; bus.ex_wr_i = wr; bus.ex_load_i = ld;
      bus.ex_dst_i = dst; bus.ex_result_i = res;
   endtask

   task automatic flush();
      drive_idle();
      repeat (DEPTH) tick();
   endtask

   task automatic test_reset();
      logic [DATA_W-1:0] ra, rb;
      rst_n = 1'b0;
      model_clear();
      drive_idle();
      ra = $urandom; rb = $urandom;
      bus.ex_rf_a_i = ra; bus.ex_rf_b_i = rb; bus.ex_rs_i = 5'd3; bus.ex_rt_i = 5'd4;
      #3;
      checks++; if (bus.op_a_o !== ra) $display("FAIL reset_op_a: got %h expected %h", bus.op_a_o, ra); else passed++;
      checks++; if (bus.op_b_o !== rb) $display("FAIL reset_op_b: got %h expected %h", bus.op_b_o, rb); else passed++;
      checks++; if (bus.sel_a_o !== 4'd0 || bus.sel_b_o !== 4'd0) $display("FAIL reset_sel: got %0d/%0d expected 0/0", bus.sel_a_o, bus.sel_b_o); else passed++;
      checks++; if (bus.stall_cnt_o !== 16'd0) $display("FAIL reset_cnt: got %0d expected 0", bus.stall_cnt_o); else passed++;
      checks++; if (bus.hazard_err_o !== 1'b0) $display("FAIL reset_haz: got %b expected 0", bus.hazard_err_o); else passed++;
      // stall is purely combinational, still visible in reset, but never counted
      set_ex(1, 1, 1, 5'd5, 32'h1);
      bus.id_rs_i = 5'd5; bus.id_use_rs_i = 1; bus.ex_rs_i = 5'd5;
      #1;
      checks++; if (bus.stall_o !== 1'b1) $display("FAIL reset_stall: got %b expected 1", bus.stall_o); else passed++;
      tick();
      checks++; if (bus.stall_cnt_o !== 16'd0) $display("FAIL reset_cnt_hold: got %0d expected 0", bus.stall_cnt_o); else passed++;
      checks++; if (bus.sel_a_o !== 4'd0) $display("FAIL reset_sel_hold: got %0d expected 0", bus.sel_a_o); else passed++;
      @(negedge clk);
      drive_idle();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_load_use();
      flush();
      set_ex(1, 1, 1, 5'd5, 32'hDEAD);
      bus.id_rs_i = 5'd5; bus.id_use_rs_i = 1;
      #1;
      checks++; if (bus.stall_o !== 1'b1) $display("FAIL ldu_stall: got %b expected 1", bus.stall_o); else passed++;
      tick();
      set_ex(0, 0, 0, 5'd0, 32'h0);
      bus.mem_ld_data_i = 32'hABCD; bus.ex_rs_i = 5'd0;
      #1;
      checks++; if (bus.stall_o !== 1'b0) $display("FAIL ldu_one_cycle: got %b expected 0", bus.stall_o); else passed++;
      checks++; if (bus.stall_cnt_o !== 16'd1) $display("FAIL ldu_cnt: got %0d expected 1", bus.stall_cnt_o); else passed++;
      tick();
      set_ex(1, 1, 0, 5'd8, 32'h1);
      bus.mem_ld_data_i = 32'h0; bus.ex_rs_i = 5'd5; bus.id_use_rs_i = 0;
      #1;
      checks++; if (bus.op_a_o !== 32'hABCD) $display("FAIL ldu_op_a: got %h expected 0000abcd", bus.op_a_o); else passed++;
      checks++; if (bus.sel_a_o !== 4'd2) $display("FAIL ldu_sel_a: got %0d expected 2", bus.sel_a_o); else passed++;
      checks++; if (bus.hazard_err_o !== 1'b0) $display("FAIL ldu_haz: got %b expected 0", bus.hazard_err_o); else passed++;
   endtask

   task automatic test_back_to_back();
      flush();
      set_ex(1, 1, 0, 5'd3, 32'h11);
      tick();
      set_ex(0, 0, 0, 5'd0, 32'h0);
      bus.ex_rs_i = 5'd3;
      #1;
      checks++; if (bus.op_a_o !== 32'h11) $display("FAIL b2b_op_a: got %h expected 00000011", bus.op_a_o); else passed++;
      checks++; if (bus.sel_a_o !== 4'd1) $display("FAIL b2b_sel_a: got %0d expected 1", bus.sel_a_o); else passed++;
      checks++; if (bus.stall_o !== 1'b0) $display("FAIL b2b_stall: got %b expected 0", bus.stall_o); else passed++;
   endtask

   task automatic test_two_apart();
      flush();
      set_ex(1, 1, 0, 5'd4, 32'h22);
      tick();
      set_ex(0, 0, 0, 5'd0, 32'h0);
      tick();
      bus.ex_rt_i = 5'd4;
      #1;
      checks++; if (bus.op_b_o !== 32'h22) $display("FAIL two_op_b: got %h expected 00000022", bus.op_b_o); else passed++;
      checks++; if (bus.sel_b_o !== 4'd2) $display("FAIL two_sel_b: got %0d expected 2", bus.sel_b_o); else passed++;
      bus.ex_rt_i = 5'd9; bus.ex_rf_b_i = 32'h99;
      #1;
      checks++; if (bus.op_b_o !== 32'h99) $display("FAIL nohit_op_b: got %h expected 00000099", bus.op_b_o); else passed++;
      checks++; if (bus.sel_b_o !== 4'd0) $display("FAIL nohit_sel_b: got %0d expected 0", bus.sel_b_o); else passed++;
   endtask

   task automatic test_priority_zero();
      flush();
      set_ex(1, 1, 0, 5'd6, 32'd1);
      tick();
      set_ex(1, 1, 0, 5'd6, 32'd2);
      tick();
      set_ex(0, 0, 0, 5'd0, 32'h0);
      bus.ex_rs_i = 5'd6;
      #1;
      checks++; if (bus.op_a_o !== 32'd2) $display("FAIL prio_op_a: got %h expected 00000002", bus.op_a_o); else passed++;
      checks++; if (bus.sel_a_o !== 4'd1) $display("FAIL prio_sel_a: got %0d expected 1", bus.sel_a_o); else passed++;
      flush();
      set_ex(1, 1, 0, 5'd0, 32'h55);
      tick();
      set_ex(1, 1, 1, 5'd0, 32'h66);
      bus.ex_rs_i = 5'd0; bus.ex_rf_a_i = 32'h77;
      bus.id_rs_i = 5'd0; bus.id_use_rs_i = 1;
      #1;
      checks++; if (bus.op_a_o !== 32'h77) $display("FAIL zero_op_a: got %h expected 00000077", bus.op_a_o); else passed++;
      checks++; if (bus.sel_a_o !== 4'd0) $display("FAIL zero_sel_a: got %0d expected 0", bus.sel_a_o); else passed++;
      checks++; if (bus.stall_o !== 1'b0) $display("FAIL zero_stall: got %b expected 0", bus.stall_o); else passed++;
   endtask

   task automatic test_hazard();
      flush();
      set_ex(1, 1, 1, 5'd7, 32'h1234);
      tick();
      set_ex(1, 1, 0, 5'd9, 32'h0);
      bus.ex_rs_i = 5'd7;
      #1;
      checks++; if (bus.hazard_err_o !== 1'b1) $display("FAIL haz_err: got %b expected 1", bus.hazard_err_o); else passed++;
      checks++; if (bus.op_a_o !== 32'h1234 || bus.sel_a_o !== 4'd1) $display("FAIL haz_stale: got %h/%0d expected 00001234/1", bus.op_a_o, bus.sel_a_o); else passed++;
   endtask

   task automatic test_reset_mid();
      logic [DATA_W-1:0] ra, rb;
      flush();
      set_ex(1, 1, 0, 5'd1, 32'hA1); tick();
      set_ex(1, 1, 0, 5'd2, 32'hA2); tick();
      set_ex(1, 1, 0, 5'd3, 32'hA3); tick();
      set_ex(1, 1, 1, 5'd4, 32'hA4);
      bus.id_rs_i = 5'd4; bus.id_use_rs_i = 1;
      ra = $urandom; rb = $urandom;
      bus.ex_rs_i = 5'd2; bus.ex_rt_i = 5'd3; bus.ex_rf_a_i = ra; bus.ex_rf_b_i = rb;
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.sel_a_o !== 4'd0 || bus.op_a_o !== ra) $display("FAIL rmid_a: got %h/%0d expected %h/0", bus.op_a_o, bus.sel_a_o, ra); else passed++;
      checks++; if (bus.sel_b_o !== 4'd0 || bus.op_b_o !== rb) $display("FAIL rmid_b: got %h/%0d expected %h/0", bus.op_b_o, bus.sel_b_o, rb); else passed++;
      checks++; if (bus.stall_cnt_o !== 16'd0) $display("FAIL rmid_cnt: got %0d expected 0", bus.stall_cnt_o); else passed++;
      checks++; if (bus.stall_o !== 1'b1) $display("FAIL rmid_stall: got %b expected 1", bus.stall_o); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      drive_idle();
      set_ex(1, 1, 0, 5'd1, 32'hBEEF);
      tick();
      set_ex(0, 0, 0, 5'd0, 32'h0);
      bus.ex_rs_i = 5'd1; bus.ex_rt_i = 5'd2; bus.ex_rf_b_i = rb;
      #1;
      checks++; if (bus.op_a_o !== 32'hBEEF || bus.sel_a_o !== 4'd1) $display("FAIL rpost_a: got %h/%0d expected 0000beef/1", bus.op_a_o, bus.sel_a_o); else passed++;
      checks++; if (bus.op_b_o !== rb || bus.sel_b_o !== 4'd0) $display("FAIL rpost_b: got %h/%0d expected %h/0", bus.op_b_o, bus.sel_b_o, rb); else passed++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         bus.ex_valid_i    = ($urandom_range(0, 3) != 0);
         bus.ex_wr_i       = ($urandom_range(0, 3) != 0);
         bus.ex_load_i     = ($urandom_range(0, 3) == 0);
         bus.ex_dst_i      = REG_W'($urandom_range(0, 7));
         bus.ex_result_i   = $urandom;
         bus.mem_ld_data_i = $urandom;
         bus.id_rs_i       = REG_W'($urandom_range(0, 7));
         bus.id_rt_i       = REG_W'($urandom_range(0, 7));
         bus.id_use_rs_i   = $urandom_range(0, 1) != 0;
         bus.id_use_rt_i   = $urandom_range(0, 1) != 0;
         bus.ex_rs_i       = REG_W'($urandom_range(0, 7));
         bus.ex_rt_i       = REG_W'($urandom_range(0, 7));
         bus.ex_rf_a_i     = $urandom;
         bus.ex_rf_b_i     = $urandom;
         #1;
         model_fwd(bus.ex_rs_i, bus.ex_rf_a_i, ea, esa, eha);
         model_fwd(bus.ex_rt_i, bus.ex_rf_b_i, eb, esb, ehb);
         checks++; if (bus.op_a_o !== ea || bus.sel_a_o !== esa) $display("FAIL rnd_a[%0d]: got %h/%0d expected %h/%0d", i, bus.op_a_o, bus.sel_a_o, ea, esa); else passed++;
         checks++; if (bus.op_b_o !== eb || bus.sel_b_o !== esb) $display("FAIL rnd_b[%0d]: got %h/%0d expected %h/%0d", i, bus.op_b_o, bus.sel_b_o, eb, esb); else passed++;
         checks++; if (bus.hazard_err_o !== (eha | ehb)) $display("FAIL rnd_haz[%0d]: got %b expected %b", i, bus.hazard_err_o, eha | ehb); else passed++;
         checks++; if (bus.stall_o !== model_stall()) $display("FAIL rnd_stall[%0d]: got %b expected %b", i, bus.stall_o, model_stall()); else passed++;
         checks++; if (bus.stall_cnt_o !== 16'(exp_cnt)) $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", i, bus.stall_cnt_o, exp_cnt); else passed++;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_back_to_back();
      test_two_apart();
      test_priority_zero();
      test_hazard();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
